// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour constants and pipeline control record
// for the multi-cursor display path.
package vga_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } vga_ctrl_t;

  function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, H/V counters and stage-0 decode (video_on, raw syncs,
// frame boundary strobe).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int PIX_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       p_tick,
  output logic       refr_tick,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_end
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = $clog2(PIX_DIV);

  logic [DIV_W-1:0] div;
  logic             h_wrap;

  assign h_wrap    = (pixel_x == 10'(H_TOTAL - 1));
  assign frame_end = p_tick && h_wrap && (pixel_y == 10'(V_DISPLAY - 1));

  assign video_on  = (pixel_x < 10'(H_DISPLAY)) && (pixel_y < 10'(V_DISPLAY));
  assign hsync_raw = !((pixel_x >= 10'(H_DISPLAY + H_FP)) &&
                       (pixel_x <  10'(H_DISPLAY + H_FP + H_SYNC)));
  assign vsync_raw = !((pixel_y >= 10'(V_DISPLAY + V_FP)) &&
                       (pixel_y <  10'(V_DISPLAY + V_FP + V_SYNC)));

  // p_tick is decoded one count early so the registered strobe coincides
  // with div == PIX_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div       <= '0;
      p_tick    <= 1'b0;
      refr_tick <= 1'b0;
      pixel_x   <= '0;
      pixel_y   <= '0;
    end else begin
      div       <= (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + 1'b1;
      p_tick    <= (div == DIV_W'(PIX_DIV - 2));
      refr_tick <= frame_end;
      if (p_tick) begin
        pixel_x <= h_wrap ? '0 : pixel_x + 1'b1;
        if (h_wrap)
          pixel_y <= (pixel_y == 10'(V_TOTAL - 1)) ? '0 : pixel_y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_multi_cursor_display.sv
// VGA top: timing generator, frame-buffered cursor shadows, per-channel hit
// detection and a 2-stage colour/sync pipeline.
module vga_multi_cursor_display
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int PIX_DIV   = 4,
  parameter int N_CUR     = 5,
  parameter int CUR_SIZE  = 8,
  parameter int RGB_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CUR*10-1:0]    cur_x,
  input  logic [N_CUR*10-1:0]    cur_y,
  input  logic [N_CUR-1:0]       cur_en,
  input  logic [N_CUR*RGB_W-1:0] cur_rgb,
  input  logic [RGB_W-1:0]       bg_rgb,
  output logic [9:0]             pixel_x,
  output logic [9:0]             pixel_y,
  output logic                   video_on,
  output logic                   p_tick,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   refr_tick,
  output logic [RGB_W-1:0]       rgb
);

  logic hsync_raw, vsync_raw, frame_end;

  logic [N_CUR*10-1:0]    sh_x, sh_y;
  logic [N_CUR-1:0]       sh_en;
  logic [N_CUR*RGB_W-1:0] sh_rgb;

  logic [N_CUR-1:0] hit, hit_q;
  vga_ctrl_t        ctrl1;
  logic [RGB_W-1:0] pix;
  logic             found;

  vga_timing_gen #(
    .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV)
  ) u_timing (
    .clk(clk), .reset(reset),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .p_tick(p_tick), .refr_tick(refr_tick),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .frame_end(frame_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_en  <= '0;
      sh_rgb <= '0;
    end else if (frame_end) begin
      sh_x   <= cur_x;
      sh_y   <= cur_y;
      sh_en  <= cur_en;
      sh_rgb <= cur_rgb;
    end
  end

  // 11-bit bounds keep cursors parked near 1023 from wrapping onto column/row 0.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < N_CUR; i++) begin
      hit[i] = sh_en[i]
        && ({1'b0, pixel_x} >= {1'b0, sh_x[10*i +: 10]})
        && ({1'b0, pixel_x} <= ({1'b0, sh_x[10*i +: 10]} + 11'(CUR_SIZE - 1)))
        && ({1'b0, pixel_y} >= {1'b0, sh_y[10*i +: 10]})
        && ({1'b0, pixel_y} <= ({1'b0, sh_y[10*i +: 10]} + 11'(CUR_SIZE - 1)));
    end
  end

  always_comb begin
    pix   = bg_rgb;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CUR; i++) begin
      if (hit_q[i] && !found) begin
        pix   = sh_rgb[RGB_W*i +: RGB_W];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q <= '0;
      ctrl1 <= '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (p_tick) begin
      hit_q <= hit;
      ctrl1 <= '{video_on: video_on, hsync: hsync_raw, vsync: vsync_raw};
      rgb   <= ctrl1.video_on ? pix : RGB_W'(BLACK);
      hsync <= ctrl1.hsync;
      vsync <= ctrl1.vsync;
    end
  end

endmodule
